// File: rtl/usb4_lane_pkg.sv
// USB4 lane initialisation shared types and defaults.
// State encodings, counter widths and default thresholds.
package usb4_lane_pkg;

  typedef enum logic [2:0] {
    ST_DISCONNECTED = 3'd0,
    ST_DISABLED     = 3'd1,
    ST_TRAINING     = 3'd2,
    ST_GEN4_TS1     = 3'd3,
    ST_GEN4_TS2     = 3'd4,
    ST_CL0          = 3'd5
  } lane_state_e;

  localparam int TS1_RX_MIN_DEF = 2;
  localparam int TS2_RX_MIN_DEF = 8;
  localparam int TS2_TX_MIN_DEF = 16;
  localparam int MAX_RETRY_DEF  = 3;

  localparam int TS1_CNT_W   = 2;
  localparam int TS2_RX_CNT_W = 4;
  localparam int TS2_TX_CNT_W = 5;
  localparam int RETRY_CNT_W  = 2;

endpackage

// File: rtl/lane_init_fsm.sv
// USB4 lane initialisation state machine (Moore, registered outputs).
// Optional retry limit: define LANE_INIT_RETRY_LIMIT_EN.
module lane_init_fsm
  import usb4_lane_pkg::*;
#(
  parameter int TS1_RX_MIN = TS1_RX_MIN_DEF,
  parameter int TS2_RX_MIN = TS2_RX_MIN_DEF,
  parameter int TS2_TX_MIN = TS2_TX_MIN_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic       clk_b,
  input  logic       rst,
  input  logic       disable_req,
  input  logic       lane_params_done,
  input  logic       tdisconnect_tx_min,
  input  logic       tconnect_rx_min,
  input  logic       tdisconnect_rx_min,
  input  logic       tdisabled_min,
  input  logic       ttraining_error_timeout,
  input  logic       tgen4_ts1_timeout,
  input  logic       tgen4_ts2_timeout,
  input  logic       ts1_rcvd,
  input  logic       ts2_rcvd,
  input  logic       ts2_sent,
  output logic       disconnected_s,
  output logic       fsm_disabled,
  output logic       fsm_training,
  output logic       ts1_gen4_s,
  output logic       ts2_gen4_s,
  output logic       cl0_s,
  output logic       sbtx,
  output logic       training_err,
  output logic [2:0] state
);

  // The retry counter is 2 bits wide, so the limit must fit in it.
  if (MAX_RETRY < 1 || MAX_RETRY > 3) begin : g_bad_max_retry
    $error("MAX_RETRY must be 1..3");
  end

  lane_state_e state_q;
  lane_state_e state_d;
  logic        err_q;
  logic        err_d;

  logic [TS1_CNT_W-1:0]    ts1_cnt;
  logic [TS2_RX_CNT_W-1:0] ts2_rx_cnt;
  logic [TS2_TX_CNT_W-1:0] ts2_tx_cnt;
  logic [TS1_CNT_W-1:0]    ts1_nxt;
  logic [TS2_RX_CNT_W-1:0] ts2_rx_nxt;
  logic [TS2_TX_CNT_W-1:0] ts2_tx_nxt;

  logic in_train;
  logic state_tmo;
  logic retry_hit;

`ifdef LANE_INIT_RETRY_LIMIT_EN
  logic [RETRY_CNT_W-1:0] retry_q;
  assign retry_hit = (int'(retry_q) + 1) >= MAX_RETRY;
`else
  assign retry_hit = 1'b0;
`endif

  // Saturating counts including this cycle's pulse, used for thresholds.
  always_comb begin
    ts1_nxt    = ts1_cnt;
    ts2_rx_nxt = ts2_rx_cnt;
    ts2_tx_nxt = ts2_tx_cnt;
    if (ts1_rcvd && (ts1_cnt != '1)) begin
      ts1_nxt = ts1_cnt + 1'b1;
    end
    if (ts2_rcvd && (ts2_rx_cnt != '1)) begin
      ts2_rx_nxt = ts2_rx_cnt + 1'b1;
    end
    if (ts2_sent && (ts2_tx_cnt != '1)) begin
      ts2_tx_nxt = ts2_tx_cnt + 1'b1;
    end
  end

  // Next-state selection, highest priority first.
  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    in_train  = (state_q == ST_TRAINING) ||
                (state_q == ST_GEN4_TS1) ||
                (state_q == ST_GEN4_TS2);
    state_tmo = ((state_q == ST_GEN4_TS1) && tgen4_ts1_timeout) ||
                ((state_q == ST_GEN4_TS2) && tgen4_ts2_timeout);
    if (state_q > ST_CL0) begin
      state_d = ST_DISCONNECTED;
    end else if (disable_req && (state_q != ST_DISABLED)) begin
      state_d = ST_DISABLED;
    end else if (tdisconnect_rx_min &&
                 (in_train || (state_q == ST_CL0))) begin
      state_d = ST_DISCONNECTED;
    end else if (in_train &&
                 (ttraining_error_timeout || state_tmo)) begin
      err_d   = 1'b1;
      state_d = retry_hit ? ST_DISABLED : ST_DISCONNECTED;
    end else begin
      unique case (state_q)
        ST_DISCONNECTED: begin
          if (tdisconnect_tx_min && tconnect_rx_min) begin
            state_d = ST_TRAINING;
          end
        end
        ST_DISABLED: begin
          if (!disable_req && tdisabled_min) begin
            state_d = ST_DISCONNECTED;
          end
        end
        ST_TRAINING: begin
          if (lane_params_done) begin
            state_d = ST_GEN4_TS1;
          end
        end
        ST_GEN4_TS1: begin
          if (int'(ts1_nxt) >= TS1_RX_MIN) begin
            state_d = ST_GEN4_TS2;
          end
        end
        ST_GEN4_TS2: begin
          if ((int'(ts2_rx_nxt) >= TS2_RX_MIN) &&
              (int'(ts2_tx_nxt) >= TS2_TX_MIN)) begin
            state_d = ST_CL0;
          end
        end
        ST_CL0: begin
          state_d = ST_CL0;
        end
        default: begin
          state_d = ST_DISCONNECTED;
        end
      endcase
    end
  end

  // State and error pulse registers.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_q <= ST_DISCONNECTED;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Counters only run while staying in their owning state; anything else
  // (exit, entry, other states) leaves them at zero.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      ts1_cnt    <= '0;
      ts2_rx_cnt <= '0;
      ts2_tx_cnt <= '0;
    end else begin
      if ((state_q == ST_GEN4_TS1) && (state_d == ST_GEN4_TS1)) begin
        ts1_cnt <= ts1_nxt;
      end else begin
        ts1_cnt <= '0;
      end
      if ((state_q == ST_GEN4_TS2) && (state_d == ST_GEN4_TS2)) begin
        ts2_rx_cnt <= ts2_rx_nxt;
        ts2_tx_cnt <= ts2_tx_nxt;
      end else begin
        ts2_rx_cnt <= '0;
        ts2_tx_cnt <= '0;
      end
    end
  end

`ifdef LANE_INIT_RETRY_LIMIT_EN
  // Training error count; cleared on link up or when the limit trips.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      retry_q <= '0;
    end else if (err_d) begin
      retry_q <= retry_hit ? '0 : retry_q + 1'b1;
    end else if ((state_d == ST_CL0) && (state_q != ST_CL0)) begin
      retry_q <= '0;
    end
  end
`endif

  // Moore output decode of the registered state.
  always_comb begin
    disconnected_s = 1'b0;
    fsm_disabled   = 1'b0;
    fsm_training   = 1'b0;
    ts1_gen4_s     = 1'b0;
    ts2_gen4_s     = 1'b0;
    cl0_s          = 1'b0;
    sbtx           = 1'b0;
    unique case (state_q)
      ST_DISCONNECTED: disconnected_s = 1'b1;
      ST_DISABLED:     fsm_disabled   = 1'b1;
      ST_TRAINING: begin
        fsm_training = 1'b1;
        sbtx         = 1'b1;
      end
      ST_GEN4_TS1: begin
        fsm_training = 1'b1;
        ts1_gen4_s   = 1'b1;
        sbtx         = 1'b1;
      end
      ST_GEN4_TS2: begin
        fsm_training = 1'b1;
        ts2_gen4_s   = 1'b1;
        sbtx         = 1'b1;
      end
      ST_CL0: begin
        cl0_s = 1'b1;
        sbtx  = 1'b1;
      end
      default: ;
    endcase
  end

  assign training_err = err_q;
  assign state        = state_q;

endmodule

// File: doc/lane_init_fsm.md
LANE_INIT_FSM -- requirements
Module: lane_init_fsm

Interface
REQ-001 SHALL have parameters: TS1_RX_MIN, default 2, TS1s received before leaving GEN4_TS1; TS2_RX_MIN, default 8, TS2s received before CL0; TS2_TX_MIN, default 16, TS2s sent before CL0; MAX_RETRY, default 3, training errors tolerated.
REQ-002 SHALL have ports: clk_b  in  1  sole clock.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 disable_req  in  1  level, requests DISABLED.
REQ-005 lane_params_done  in  1  pulse, sideband parameter exchange complete.
REQ-006 tdisconnect_tx_min, tconnect_rx_min, tdisconnect_rx_min, tdisabled_min, ttraining_error_timeout, tgen4_ts1_timeout, tgen4_ts2_timeout  in  1 each  timer flags, clk_b-synchronous.
REQ-007 ts1_rcvd, ts2_rcvd, ts2_sent  in  1 each  single-cycle pulses.
REQ-008 disconnected_s, fsm_disabled, fsm_training, ts1_gen4_s, ts2_gen4_s  out  1 each  timer enables.
REQ-009 cl0_s  out  1  link up; sbtx  out  1  sideband TX level; training_err  out  1  one-cycle error pulse; state  out  3  encoded state.

Function
REQ-010 States/encodings SHALL be DISCONNECTED=0, DISABLED=1, TRAINING=2, GEN4_TS1=3, GEN4_TS2=4, CL0=5; codes 6-7 SHALL transition to DISCONNECTED.
REQ-011 All outputs SHALL be registered Moore decodes: condition sampled at edge N -> new state and outputs visible after edge N.
REQ-012 DISCONNECTED: disconnected_s=1, sbtx=0; -> TRAINING when tdisconnect_tx_min && tconnect_rx_min.
REQ-013 DISABLED: fsm_disabled=1, sbtx=0; -> DISCONNECTED when !disable_req && tdisabled_min.
REQ-014 TRAINING: fsm_training=1, sbtx=1; -> GEN4_TS1 on lane_params_done.
REQ-015 GEN4_TS1: fsm_training=1, ts1_gen4_s=1, sbtx=1; -> GEN4_TS2 when ts1 count >= TS1_RX_MIN; tgen4_ts1_timeout = training error.
REQ-016 GEN4_TS2: fsm_training=1, ts2_gen4_s=1, sbtx=1; -> CL0 when ts2 rx count >= TS2_RX_MIN and ts2 tx count >= TS2_TX_MIN; tgen4_ts2_timeout = training error.
REQ-017 CL0: cl0_s=1, sbtx=1.
REQ-018 Priority per cycle: disable_req (any state except DISABLED -> DISABLED) > tdisconnect_rx_min (TRAINING/GEN4_TS1/GEN4_TS2/CL0 -> DISCONNECTED) > ttraining_error_timeout or state timeout (TRAINING/GEN4_TS1/GEN4_TS2) > progress condition.
REQ-019 Training error SHALL assert training_err for exactly one cycle, coincident with the exit transition, next state DISCONNECTED (see REQ-025).
REQ-020 Counters: ts1 rx 2 bits, ts2 rx 4 bits, ts2 tx 5 bits; each SHALL saturate at all-ones, never wrap, and clear on entry to the state that uses it.
REQ-021 Pulses arriving outside the owning state SHALL be ignored; a pulse in the same cycle as the state exit SHALL not be counted.
REQ-022 Threshold compares SHALL use the value including the current-cycle pulse (transition in the cycle the threshold-th pulse arrives).

Reset
REQ-023 rst high at clock edge SHALL force DISCONNECTED, all counters 0, disconnected_s=1, all other outputs 0, state=0, regardless of current state.
REQ-024 rst SHALL dominate every other input including disable_req.

Configuration
REQ-025 Macro LANE_INIT_RETRY_LIMIT_EN: when defined, a 2-bit retry counter SHALL increment per training error, clear on CL0 entry and reset, and the error reaching MAX_RETRY SHALL go to DISABLED (counter cleared) instead of DISCONNECTED; when undefined, no counter exists and every training error goes to DISCONNECTED.

Structure
REQ-026 State encodings and default parameter constants SHALL live in shared package usb4_lane_pkg.
REQ-027 Single module; no sub-module required, counters inline.

Verification
REQ-028 Reset mid-GEN4_TS2 -> next cycle state=0, disconnected_s=1, counters 0.
REQ-029 Connect: tdisconnect_tx_min=1, tconnect_rx_min=1, lane_params_done pulse, 2 ts1_rcvd, 8 ts2_rcvd + 16 ts2_sent -> states 0,2,3,4,5; cl0_s=1 in cycle after 16th ts2_sent.
REQ-030 In GEN4_TS1 assert tgen4_ts1_timeout -> training_err 1 cycle, state=0; with macro, third such error -> state=1.
REQ-031 In CL0 assert disable_req and tdisconnect_rx_min same cycle -> state=1; deassert disable_req, pulse tdisabled_min -> state=0.
REQ-032 20 ts2_rcvd pulses in GEN4_TS2 with ts2_sent withheld -> rx counter holds 15, no CL0, no wrap.
